pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Small registered FIFO with valid/ready handshake, so a stage can absorb back-pressure without a global stall.
- Keeps the existing pipeline controls: hold freezes the stage, and flush kills its contents and produces bubbles.
- Bubble is defined as all-zero data; empty outputs drive '0.

Parameters:
- WIDTH, 64: payload width in bits (packed stage struct).
- DEPTH, 2: number of entries. Legal range 1..4; DEPTH=1 behaves as a plain stage register.
- CW, $clog2(DEPTH+1): width of the count output (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents a valid entry
- in_ready  out  1  buffer accepts this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- out_data  out  WIDTH  head payload; '0 when empty
- flush  in  1  kill all entries (branch/jump redirect)
- hold  in  1  freeze all state (memory handshake stall)
- count  out  CW  number of occupied entries
- flush_pending  out  1  a flush arrived during hold and is still deferred

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH entries with head pointer, tail pointer and count registers.
  - Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- Reset (synchronous, highest priority): count=0, head=0, tail=0, flush_pending=0. Storage contents are don't-care, but out_data must read '0 because out_valid=0.
- Outputs are purely registered. There is no combinational path from in_* or out_ready to out_valid or out_data.
- Output encoding:
  - out_valid = (count!=0).
  - out_data = storage[head] if out_valid, else '0.
- in_ready = !hold && !flush_eff && (count<DEPTH).
  - No dependence on out_ready.
  - A full buffer refuses input even when it is being drained in the same cycle.
- flush_eff = !hold && (flush || flush_pending).
- Per-cycle priority: reset > hold > flush_eff > normal.
- hold=1:
  - All registers keep their values, including storage, pointers and count.
  - No enqueue or dequeue occurs, even if in_valid or out_ready is asserted.
  - If flush=1 during hold, set flush_pending=1.
  - This mirrors the existing rule that a stall dominates a redirect; the redirect is deferred, not dropped.
- flush_eff=1 (and hold=0):
  - count=0, head=tail=0, flush_pending=0 on the next edge.
  - in_ready=0 this cycle, so no enqueue.
  - A concurrent out_ready handshake is ignored: out_valid may be high, but the entry counts as killed. Downstream must treat a cycle with flush asserted as a non-transfer; the top level guarantees this.
- Normal operation:
  - enq = in_valid && in_ready: write storage[tail], advance tail.
  - deq = out_valid && out_ready: advance head.
  - count' = count + enq - deq.
  - Simultaneous enq and deq keeps count unchanged.
- Latency: an entry accepted at edge N is visible on out_* after edge N (next cycle), when the buffer is empty or once it reaches the head.
- Throughput:
  - DEPTH>=2 sustains 1 transfer/cycle with out_ready held high.
  - DEPTH=1 sustains 1 transfer every 2 cycles. This is accepted; DEPTH=1 is for non-critical stages.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - in_data must stay stable while in_valid && !in_ready is not required; upstream may change it.

Test Plan:
- Reset then streaming: WIDTH=64, DEPTH=2. Push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data shows 0x11, 0x22, 0x33 on cycles 1, 2, 3 after each accept; count stays ≤1; in_ready stays 1.
- Back-pressure fill: out_ready=0, push 0xA, 0xB, 0xC -> 0xA and 0xB accepted, count=2, in_ready=0, 0xC held upstream. Raise out_ready -> 0xA, 0xB, 0xC are delivered in order, none lost or duplicated.
- Flush: with count=2, assert flush for 1 cycle -> next cycle count=0, out_valid=0, out_data=0. The in_valid entry in the flush cycle is not accepted.
- Hold defers flush: count=1 with head 0x5. Assert hold for 3 cycles with flush pulsed in the 2nd -> out_data stays 0x5, count=1, flush_pending=1. On the first cycle hold=0, the flush applies: next cycle count=0 and flush_pending=0.
- Wrap-around: DEPTH=3, 10 pushes 0x1..0xA with out_ready toggling 1,0,1,0 -> output order is exactly 0x1..0xA, and the pointers wrap at least twice.
- Reset mid-operation: count=2 with reset asserted 1 cycle -> count=0, out_valid=0, flush_pending=0. A push in the following cycle appears on out_data one cycle later.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Registered inter-stage buffer: a small circular FIFO with valid/ready handshake,
// keeping the classic hold (freeze) and flush (kill to bubbles) pipeline controls.
module pipe_stage_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             hold,
  output logic [CW-1:0]    count,
  output logic             flush_pending
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             flush_eff;
  logic             enq;
  logic             deq;

  // Explicit wrap so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign flush_eff = !hold && (flush || flush_pending);
  assign in_ready  = !hold && !flush_eff && (count < FULL);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? storage[head] : '0;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready && !hold && !flush_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      head          <= '0;
      tail          <= '0;
      flush_pending <= 1'b0;
    end else if (hold) begin
      // A stall wins over a redirect, but the redirect is remembered.
      if (flush) flush_pending <= 1'b1;
    end else if (flush_eff) begin
      count         <= '0;
      head          <= '0;
      tail          <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (enq) tail <= next_ptr(tail);
      if (deq) head <= next_ptr(head);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) storage[tail] <= in_data;
  end

`ifndef SYNTHESIS
  count_in_range: assert property (@(posedge clk) disable iff (reset) count <= FULL);
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH=2 and DEPTH=3 instances checked every cycle against
// a queue-based model, plus directed scenarios with literal expectations.
module tb_pipe_stage_buf;

  localparam int MD [2] = '{2, 3};

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;
  logic        flush;
  logic        hold;
  logic        ivld [2];
  logic [63:0] idat [2];
  logic        irdy [2];
  logic        ovld [2];
  logic [63:0] odat [2];
  logic [1:0]  cnt  [2];
  logic        fpo  [2];

  logic [63:0] mq  [2][$];
  bit          mfp [2];
  logic [63:0] src [2][$];
  logic [63:0] dlv [2][$];
  bit          cmpEn = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(64), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(ivld[0]), .in_ready(irdy[0]), .in_data(idat[0]),
    .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odat[0]), .flush(flush),
    .hold(hold), .count(cnt[0]), .flush_pending(fpo[0]));

  pipe_stage_buf #(.WIDTH(64), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(ivld[1]), .in_ready(irdy[1]), .in_data(idat[1]),
    .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odat[1]), .flush(flush),
    .hold(hold), .count(cnt[1]), .flush_pending(fpo[1]));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the buffer is just an ordered list of entries bounded by DEPTH.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit acc;
      if (reset) begin
        mq[k].delete();
        mfp[k] = 1'b0;
      end else if (hold) begin
        if (flush) mfp[k] = 1'b1;
      end else if (flush || mfp[k]) begin
        mq[k].delete();
        mfp[k] = 1'b0;
      end else begin
        acc = ivld[k] && (mq[k].size() < MD[k]);
        if (mq[k].size() != 0 && out_ready) void'(mq[k].pop_front());
        if (acc) mq[k].push_back(idat[k]);
      end
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      for (int k = 0; k < 2; k++) begin
        string p;
        bit    expRdy;
        p = $sformatf("d%0d", MD[k]);
        expRdy = !hold && !(flush || mfp[k]) && (mq[k].size() < MD[k]);
        checkOutput({p, "_out_valid"}, 64'(ovld[k]), 64'(mq[k].size() != 0));
        checkOutput({p, "_out_data"}, odat[k], (mq[k].size() != 0) ? mq[k][0] : 64'h0);
        checkOutput({p, "_count"}, 64'(cnt[k]), 64'(mq[k].size()));
        checkOutput({p, "_flush_pending"}, 64'(fpo[k]), 64'(mfp[k]));
        checkOutput({p, "_in_ready"}, 64'(irdy[k]), 64'(expRdy));
        if (!reset && ovld[k] && out_ready && !hold && !(flush || mfp[k]))
          dlv[k].push_back(odat[k]);
      end
    end
  end

  task automatic redrive();
    for (int k = 0; k < 2; k++) begin
      ivld[k] = (src[k].size() != 0);
      idat[k] = (src[k].size() != 0) ? src[k][0] : 64'h0;
    end
  endtask

  task automatic pushBoth(input logic [63:0] d);
    src[0].push_back(d);
    src[1].push_back(d);
    redrive();
  endtask

  // Set the control inputs for one cycle; the upstream source advances on each handshake.
  task automatic applyStimulus(input bit ordy, input bit fl, input bit hd, input bit rst);
    bit acc [2];
    out_ready = ordy;
    flush     = fl;
    hold      = hd;
    reset     = rst;
    @(negedge clk);
    for (int k = 0; k < 2; k++) acc[k] = ivld[k] && irdy[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) if (acc[k]) void'(src[k].pop_front());
    redrive();
  endtask

  task automatic checkLog(input string name, input int k, input logic [63:0] exp []);
    checkOutput({name, "_len"}, 64'(dlv[k].size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      checkOutput($sformatf("%s_%0d", name, i), (i < dlv[k].size()) ? dlv[k][i] : 64'hFFFF_FFFF_FFFF_FFFF, exp[i]);
  endtask

  initial begin
    logic [63:0] expAbc [];
    logic [63:0] expWrap [];
    out_ready = 1'b0; flush = 1'b0; hold = 1'b0; reset = 1'b1;
    redrive();
    @(posedge clk);
    #1;
    cmpEn = 1'b1;
    applyStimulus(0, 0, 0, 1);
    checkOutput("reset_count", 64'(cnt[0]), 64'h0);
    checkOutput("reset_out_valid", 64'(ovld[0]), 64'h0);
    checkOutput("reset_out_data", odat[0], 64'h0);
    checkOutput("reset_flush_pending", 64'(fpo[0]), 64'h0);

    // Streaming with out_ready held high
    pushBoth(64'h11); pushBoth(64'h22); pushBoth(64'h33);
    applyStimulus(1, 0, 0, 0);
    checkOutput("stream_data0", odat[0], 64'h11);
    checkOutput("stream_count0", 64'(cnt[0]), 64'h1);
    checkOutput("stream_ready0", 64'(irdy[0]), 64'h1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("stream_data1", odat[0], 64'h22);
    checkOutput("stream_count1", 64'(cnt[0]), 64'h1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("stream_data2", odat[0], 64'h33);
    checkOutput("stream_ready2", 64'(irdy[0]), 64'h1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("stream_drained", 64'(cnt[0]), 64'h0);

    // Back-pressure fill then drain
    dlv[0].delete(); dlv[1].delete();
    pushBoth(64'hA); pushBoth(64'hB); pushBoth(64'hC);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("bp_count", 64'(cnt[0]), 64'h2);
    checkOutput("bp_in_ready", 64'(irdy[0]), 64'h0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("bp_c_held", 64'(src[0].size()), 64'h1);
    checkOutput("bp_d3_count", 64'(cnt[1]), 64'h3);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
    expAbc = '{64'hA, 64'hB, 64'hC};
    checkLog("bp_order_d2", 0, expAbc);
    checkLog("bp_order_d3", 1, expAbc);

    // Flush with two entries and a waiting input
    pushBoth(64'hA1); pushBoth(64'hB2);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("flush_pre_count", 64'(cnt[0]), 64'h2);
    pushBoth(64'hC3);
    applyStimulus(0, 1, 0, 0);
    checkOutput("flush_count", 64'(cnt[0]), 64'h0);
    checkOutput("flush_out_valid", 64'(ovld[0]), 64'h0);
    checkOutput("flush_out_data", odat[0], 64'h0);
    checkOutput("flush_not_accepted", 64'(src[0].size()), 64'h1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("flush_next_data", odat[0], 64'hC3);
    applyStimulus(1, 0, 0, 0);

    // Hold defers a flush
    pushBoth(64'h5);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("hold1_data", odat[0], 64'h5);
    checkOutput("hold1_fp", 64'(fpo[0]), 64'h0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("hold2_data", odat[0], 64'h5);
    checkOutput("hold2_count", 64'(cnt[0]), 64'h1);
    checkOutput("hold2_fp", 64'(fpo[0]), 64'h1);
    applyStimulus(1, 0, 1, 0);
    checkOutput("hold3_data", odat[0], 64'h5);
    checkOutput("hold3_count", 64'(cnt[0]), 64'h1);
    checkOutput("hold3_fp", 64'(fpo[0]), 64'h1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("hold_release_count", 64'(cnt[0]), 64'h0);
    checkOutput("hold_release_fp", 64'(fpo[0]), 64'h0);

    // Wrap-around with toggling out_ready
    dlv[0].delete(); dlv[1].delete();
    for (int i = 1; i <= 10; i++) pushBoth(64'(i));
    for (int c = 0; c < 60 && !(dlv[0].size() >= 10 && dlv[1].size() >= 10); c++)
      applyStimulus(c % 2 == 0, 0, 0, 0);
    expWrap = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h6, 64'h7, 64'h8, 64'h9, 64'hA};
    checkLog("wrap_d2", 0, expWrap);
    checkLog("wrap_d3", 1, expWrap);

    // Reset in the middle of operation
    pushBoth(64'h31); pushBoth(64'h42);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("midrst_pre_count", 64'(cnt[0]), 64'h2);
    applyStimulus(0, 0, 0, 1);
    checkOutput("midrst_count", 64'(cnt[0]), 64'h0);
    checkOutput("midrst_out_valid", 64'(ovld[0]), 64'h0);
    checkOutput("midrst_fp", 64'(fpo[0]), 64'h0);
    pushBoth(64'h77);
    applyStimulus(0, 0, 0, 0);
    checkOutput("midrst_push_data", odat[0], 64'h77);
    checkOutput("midrst_push_valid", 64'(ovld[0]), 64'h1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
